// File: rtl/lu_issue_queue_if.sv
// Command and result handshake bundle between a producer/consumer and the
// logic-unit issue queue.
interface lu_issue_queue_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       in_sel1;
  logic       in_sel0;
  logic       in_chain;
  logic       out_valid;
  logic [7:0] out_f;
  logic       out_ready;

  modport master (
    output in_valid, in_x, in_y, in_sel1, in_sel0, in_chain, out_ready,
    input  in_ready, out_valid, out_f
  );

  modport slave (
    input  in_valid, in_x, in_y, in_sel1, in_sel0, in_chain, out_ready,
    output in_ready, out_valid, out_f
  );
endinterface

// File: rtl/lu_issue_queue.sv
// Command FIFO and issue stage feeding an external 8-bit logic unit; the
// returned result is captured into a valid/ready output holding register.
module lu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  lu_issue_queue_if.slave          bus,
  output logic [7:0]               lu_x,
  output logic [7:0]               lu_y,
  output logic                     lu_sel1,
  output logic                     lu_sel0,
  input  logic [7:0]               lu_f,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               last_f
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       sel1;
    logic       sel0;
    logic       chain;
  } cmd_t;

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        head;
  logic        empty;
  logic        push;
  logic        issue;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (count == '0);
  assign bus.in_ready = (count != (AW + 1)'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign issue        = !empty && (!bus.out_valid || bus.out_ready);
  assign head         = mem[rd_ptr[AW-1:0]];

  // Chain is resolved here, at issue time, so it always sees the newest result.
  always_comb begin
    lu_x    = '0;
    lu_y    = '0;
    lu_sel1 = 1'b0;
    lu_sel0 = 1'b0;
    if (!empty) begin
      lu_x    = head.chain ? last_f : head.x;
      lu_y    = head.y;
      lu_sel1 = head.sel1;
      lu_sel0 = head.sel0;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are live, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{x:     bus.in_x,
                              y:     bus.in_y,
                              sel1:  bus.in_sel1,
                              sel0:  bus.in_sel0,
                              chain: bus.in_chain};
    end
  end

  // NOTE: all registered state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_f     <= '0;
      last_f        <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr        <= rd_ptr + 1'b1;
        bus.out_valid <= 1'b1;
        bus.out_f     <= lu_f;
        last_f        <= lu_f;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lu_issue_queue.sv
// Self-checking bench for lu_issue_queue: a queue-based cycle model plus an
// in-order result scoreboard, with directed and randomized stimulus.
module tb_lu_issue_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       s1;
    logic       s0;
    logic       ch;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lu_issue_queue_if bus ();

  logic [7:0]              lu_x;
  logic [7:0]              lu_y;
  logic                    lu_sel1;
  logic                    lu_sel0;
  logic [7:0]              lu_f;
  logic [$clog2(DEPTH):0]  count;
  logic [7:0]              last_f;

  lu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .lu_x    (lu_x),
    .lu_y    (lu_y),
    .lu_sel1 (lu_sel1),
    .lu_sel0 (lu_sel0),
    .lu_f    (lu_f),
    .count   (count),
    .last_f  (last_f)
  );

  function automatic logic [7:0] lu_op(input logic [7:0] x, input logic [7:0] y,
                                       input logic s1, input logic s0);
    case ({s1, s0})
      2'b00:   return x | y;
      2'b01:   return x & y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // The logic unit itself lives outside the DUT.
  always_comb lu_f = lu_op(lu_x, lu_y, lu_sel1, lu_sel0);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model state and in-order expected results.
  cmd_t       mq[$];
  logic       m_ov;
  logic [7:0] m_of;
  logic [7:0] m_last;
  logic [7:0] res_q[$];
  logic [7:0] ref_last;
  bit         run = 1'b0;

  task automatic model_reset();
    mq.delete();
    res_q.delete();
    m_ov     = 1'b0;
    m_of     = '0;
    m_last   = '0;
    ref_last = '0;
  endtask

  // Called just after a rising edge: evaluates one cycle against current inputs.
  task automatic cycle(output bit pushed);
    bit         issue;
    cmd_t       c;
    cmd_t       nc;
    logic [7:0] r;
    logic [7:0] exp_r;
    logic       n_ov;
    logic [7:0] n_of;
    logic [7:0] n_last;
    if (m_ov && bus.out_ready) begin
      if (res_q.size() == 0) begin
        check("sb_unexpected_result", 32'(bus.out_f), 32'hFFFF_FFFF);
      end else begin
        exp_r = res_q.pop_front();
        check("sb_result", 32'(bus.out_f), 32'(exp_r));
      end
    end
    issue  = (mq.size() != 0) && (!m_ov || bus.out_ready);
    pushed = bus.in_valid && (mq.size() != DEPTH);
    n_ov   = m_ov;
    n_of   = m_of;
    n_last = m_last;
    if (issue) begin
      c      = mq[0];
      r      = lu_op(c.ch ? m_last : c.x, c.y, c.s1, c.s0);
      n_ov   = 1'b1;
      n_of   = r;
      n_last = r;
    end else if (bus.out_ready) begin
      n_ov = 1'b0;
    end
    if (pushed) begin
      nc.x  = bus.in_x;
      nc.y  = bus.in_y;
      nc.s1 = bus.in_sel1;
      nc.s0 = bus.in_sel0;
      nc.ch = bus.in_chain;
      // Results come out strictly in push order, so the chained x is simply
      // the previous command's result.
      exp_r    = lu_op(nc.ch ? ref_last : nc.x, nc.y, nc.s1, nc.s0);
      ref_last = exp_r;
      res_q.push_back(exp_r);
    end
    @(posedge clk);
    if (issue) mq.delete(0);
    if (pushed) mq.push_back(nc);
    m_ov   = n_ov;
    m_of   = n_of;
    m_last = n_last;
    #1;
  endtask

  always @(negedge clk) begin : cmp
    cmd_t h;
    if (run && rst_n) begin
      check("count", 32'(count), 32'(mq.size()));
      check("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
      check("out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("out_f", 32'(bus.out_f), 32'(m_of));
      check("last_f", 32'(last_f), 32'(m_last));
      if (mq.size() == 0) begin
        check("lu_idle", {14'd0, lu_x, lu_y, lu_sel1, lu_sel0}, 32'd0);
      end else begin
        h = mq[0];
        check("lu_x", 32'(lu_x), 32'(h.ch ? m_last : h.x));
        check("lu_y", 32'(lu_y), 32'(h.y));
        check("lu_sel", {30'd0, lu_sel1, lu_sel0}, {30'd0, h.s1, h.s0});
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y,
                       input logic s1, input logic s0, input logic ch);
    bus.in_valid = v;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_sel1  = s1;
    bus.in_sel0  = s0;
    bus.in_chain = ch;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic s1, input logic s0, input logic ch);
    bit p = 1'b0;
    drive(1'b1, x, y, s1, s0, ch);
    for (int k = 0; k < 50 && !p; k++) cycle(p);
    if (!p) check("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit p;
    bus.in_valid = 1'b0;
    repeat (n) cycle(p);
  endtask

  task automatic drain(input bit toggle);
    bit p;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (mq.size() == 0 && !m_ov) break;
      bus.out_ready = toggle ? logic'(k % 2) : 1'b1;
      cycle(p);
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] single_exp [4];
    bit         p;
    int         sent;
    single_exp = '{8'h7F, 8'h04, 8'h7B, 8'h93};

    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_f", 32'(bus.out_f), 32'h00);
    check("rst_last_f", 32'(last_f), 32'h00);
    check("rst_lu", {14'd0, lu_x, lu_y, lu_sel1, lu_sel0}, 32'd0);
    rst_n = 1'b1;
    run   = 1'b1;

    // Single ops, one per select, each visible one cycle after accept.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] sel;
      sel = 2'(i);
      send(8'b0110_1100, 8'b0001_0111, sel[1], sel[0], 1'b0);
      check("single_no_bypass", 32'(bus.out_valid), 32'd0);
      idle(1);
      check("single_out_valid", 32'(bus.out_valid), 32'd1);
      check("single_out_f", 32'(bus.out_f), 32'(single_exp[i]));
    end
    idle(1);

    // Streaming four commands on consecutive edges.
    for (int k = 0; k < 4; k++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check("stream_count_le1", 32'(count <= 1), 32'd1);
      check("stream_out_valid", 32'(bus.out_valid), 32'(k >= 1));
    end
    idle(1);
    check("stream_tail_valid", 32'(bus.out_valid), 32'd1);
    idle(1);
    check("stream_end_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: DEPTH in the FIFO plus one held in the output register.
    bus.out_ready = 1'b0;
    send(8'hA5, 8'h0F, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 5; k++) send(8'(8'h10 + k), 8'(k * 3), 1'($urandom), 1'($urandom), 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_out_f", 32'(bus.out_f), 32'hAF);
    drive(1'b1, 8'h66, 8'h99, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      cycle(p);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_out_f", 32'(bus.out_f), 32'hAF);
    end
    bus.out_ready = 1'b1;
    cycle(p);
    check("first_pop_count", 32'(count), 32'd3);
    check("first_pop_in_ready", 32'(bus.in_ready), 32'd1);
    cycle(p);
    check("sixth_accept_count", 32'(count), 32'd3);
    drain(1'b0);

    // Chaining, back-to-back.
    bus.out_ready = 1'b1;
    send(8'hFF, 8'h0F, 1'b1, 1'b0, 1'b0);
    send(8'h5A, 8'h00, 1'b1, 1'b1, 1'b1);
    check("chain_xor", 32'(bus.out_f), 32'hF0);
    send(8'h81, 8'h3C, 1'b0, 1'b1, 1'b1);
    check("chain_not", 32'(bus.out_f), 32'h0F);
    idle(1);
    check("chain_and", 32'(bus.out_f), 32'h0C);
    drain(1'b0);
    check("chain_last_f", 32'(last_f), 32'h0C);

    // Chaining again with the consumer toggling ready.
    bus.out_ready = 1'b0;
    send(8'hFF, 8'h0F, 1'b1, 1'b0, 1'b0);
    send(8'h33, 8'hC3, 1'b1, 1'b1, 1'b1);
    send(8'h77, 8'h3C, 1'b0, 1'b1, 1'b1);
    drain(1'b1);
    check("chain_toggle_last_f", 32'(last_f), 32'h0C);

    // Asynchronous reset mid-stream with three queued and one held.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_f", 32'(bus.out_f), 32'h00);
    check("mid_rst_last_f", 32'(last_f), 32'h00);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_lu", {14'd0, lu_x, lu_y, lu_sel1, lu_sel0}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(3);
    check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);

    // Randomized traffic across several pointer wraps.
    sent = 0;
    drive(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    for (int g = 0; g < 2000 && sent < 3 * DEPTH * 3; g++) begin
      bus.out_ready = 1'($urandom);
      cycle(p);
      if (p) sent++;
      if (p || !bus.in_valid) begin
        drive(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
    end
    check("rand_all_sent", 32'(sent), 32'(3 * DEPTH * 3));
    drain(1'b0);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lu_issue_queue.md
# lu_issue_queue

Command queue and issue stage that sits directly upstream of the 8-bit logic unit (OR/AND/XOR/NOT selected by `sel1`/`sel0`). It buffers operation commands from a producer, drives the logic unit's `x`, `y`, `sel1` and `sel0` inputs from the head command, and registers the returned `f` into an output holding register. The output register has a valid/ready handshake. Results can be chained, so the previous result replaces `x` for the next operation.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, ≥2. Data width is fixed at 8 to match the logic unit.

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  command present
- `in_ready`  out  1  FIFO not full
- `in_x`  in  8  operand x
- `in_y`  in  8  operand y
- `in_sel1`, `in_sel0`  in  1 each  op select: 00 OR, 01 AND, 10 XOR, 11 NOT x
- `in_chain`  in  1  1 = use `last_f` as x instead of `in_x`
- `lu_x`, `lu_y`  out  8 each  to logic unit `x`/`y`
- `lu_sel1`, `lu_sel0`  out  1 each  to logic unit `sel1`/`sel0`
- `lu_f`  in  8  logic unit result, combinational from `lu_*`
- `out_valid`  out  1  result held
- `out_f`  out  8  registered result
- `out_ready`  in  1  consumer accepts
- `count`  out  clog2(DEPTH)+1  FIFO occupancy, excluding the output register
- `last_f`  out  8  most recently captured result

## Operation
- Push: `in_valid && in_ready` at an edge writes {`in_x`, `in_y`, `in_sel1`, `in_sel0`, `in_chain`} at the write pointer.
- `in_ready` = (`count` != DEPTH). It is registered-state only, with no combinational path from `out_ready`. A full FIFO refuses a push even in a cycle where it pops.
- Output register is free when `!out_valid || out_ready`.
- Issue condition: FIFO non-empty and output register free.
- When the FIFO is non-empty, `lu_*` are driven combinationally from the head entry:
  - `lu_x` = head.chain ? `last_f` : head.x
  - `lu_y` = head.y
  - `lu_sel1`, `lu_sel0` = head.sel1, head.sel0
- When the FIFO is empty, `lu_x`, `lu_y`, `lu_sel1` and `lu_sel0` are all 0.
- Issue edge:
  - `out_f` ← `lu_f`
  - `last_f` ← `lu_f`
  - `out_valid` ← 1
  - head is popped
- Without an issue, `out_ready && out_valid` clears `out_valid`. `out_f` holds its value.
- `out_f` is stable while `out_valid && !out_ready`.
- Chain resolves at issue time, not accept time, so back-to-back chained commands see the immediately preceding result.
- Pointers wrap modulo DEPTH. `count` changes by +1 (push only), −1 (pop only), or 0 (both or neither).
- The NOT op ignores `lu_y`; `lu_y` is still driven from head.y.

## Timing
- Reset (async assert, any cycle) clears:
  - pointers, so `count`=0 and `in_ready`=1
  - `out_valid`=0, `out_f`=0x00, `last_f`=0x00
  - `lu_x`, `lu_y`, `lu_sel1`, `lu_sel0` = 0
- Reset flushes all queued and held commands without emitting them.
- Deassertion is synchronised externally; the first push can occur at the first edge after release.
- Latency: command accepted at edge N into an empty FIFO with a free output gives `out_valid`=1 after edge N+1. There is no same-cycle bypass.
- Throughput: one result per cycle while `out_ready`=1 and the FIFO is non-empty.
- Backpressure: with `out_ready`=0, capacity is DEPTH + 1 commands: DEPTH in the FIFO plus 1 in the output register.
- Empty FIFO with `out_valid && out_ready` gives `out_valid`=0 next cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with 3 queued commands and `out_valid`=1 → immediately `count`=0, `out_valid`=0, `out_f`=0x00, `last_f`=0x00, `in_ready`=1. No stale result appears after release.
- Single ops: x=01101100, y=00010111, `out_ready`=1, one command per select:
  - sel 00 → 01111111
  - sel 01 → 00000100
  - sel 10 → 01111011
  - sel 11 → 10010011
  - each result appears with `out_valid` one cycle after accept
- Streaming: 4 commands on consecutive edges with `out_ready`=1 → `out_valid` high for 4 consecutive cycles starting edge N+1, results in order, `count` ≤1.
- Backpressure/full: `out_ready`=0, offer 6 commands →
  - first lands in the output register
  - next 4 fill the FIFO, `count`=4, `in_ready`=0
  - 6th is stalled
  - `out_f` is stable throughout
  - raising `out_ready` drains all 6 in order; `in_ready` reasserts the edge after the first pop
- Chaining: XOR x=0xFF y=0x0F → 0xF0; then chain NOT → 0x0F; then chain AND y=0x3C → 0x0C. Issue back-to-back, and repeat with `out_ready` toggling 1/0; `last_f` ends at 0x0C.
- Wrap: 3×DEPTH commands with random `in_valid`/`out_ready` → scoreboard matches the reference op results in order, and there is no loss or duplication across pointer wrap.
